// File: rtl/bpred_pkg.sv
// Shared types, widths and helpers for the perceptron direction predictor.
package bpred_pkg;

  localparam int WBITS_DEF = 8;
  localparam int HIST_DEF  = 12;

  function automatic int sum_width(int wbits, int hist);
    return wbits + $clog2(hist + 2);
  endfunction

  function automatic int sat_limit(int wbits);
    return (2 ** (wbits - 1)) - 1;
  endfunction

  localparam int SAT_MAX_DEF = sat_limit(WBITS_DEF);
  localparam int SAT_MIN_DEF = -SAT_MAX_DEF;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    UPD_WR = 2'd2
  } state_t;

  // Row layout: weight i in field i, bias in field HIST.
  typedef logic signed [WBITS_DEF-1:0] weight_t;
  typedef weight_t [HIST_DEF:0]        weight_row_t;

endpackage

// File: rtl/perceptron_sum.sv
// Combinational perceptron dot product: bias plus conditionally negated weights.
module perceptron_sum #(
  parameter int HIST  = 12,
  parameter int WBITS = 8,
  parameter int SW    = 12
) (
  input  logic [(HIST+1)*WBITS-1:0] row,
  input  logic [HIST-1:0]           ghr,
  output logic signed [SW-1:0]      sum
);

  logic signed [SW-1:0] term;

  always_comb begin
    term = '0;
    sum  = {{(SW-WBITS){row[HIST*WBITS+WBITS-1]}}, row[HIST*WBITS +: WBITS]};
    for (int i = 0; i < HIST; i++) begin
      term = {{(SW-WBITS){row[i*WBITS+WBITS-1]}}, row[i*WBITS +: WBITS]};
      sum  = ghr[i] ? (sum + term) : (sum - term);
    end
  end

endmodule

// File: rtl/perceptron_predictor.sv
// Perceptron branch direction predictor with speculative GHR, recovery,
// threshold-gated saturating training and a post-reset table clear.
module perceptron_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int HIST    = 12,
  parameter int WBITS   = 8,
  parameter int THETA   = 37,
  localparam int SW     = sum_width(WBITS, HIST)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lu_valid,
  input  logic [31:0]          lu_pc,
  output logic                 lu_ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic signed [SW-1:0] pred_sum,
  output logic [HIST-1:0]      pred_ghr,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [31:0]          up_pc,
  input  logic [HIST-1:0]      up_ghr,
  input  logic [SW-1:0]        up_sum,
  input  logic                 up_taken,
  input  logic                 up_mispred,
  output logic                 init_done
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int ROWW = (HIST + 1) * WBITS;
  localparam int LIM  = sat_limit(WBITS);
  localparam logic [IDXW-1:0]        IDX_MAX = '1;
  localparam logic signed [WBITS:0]  LIM_X   = (WBITS+1)'(LIM);
  localparam logic signed [WBITS:0]  ONE_X   = (WBITS+1)'(1);
  localparam logic signed [SW:0]     THETA_X = (SW+1)'(THETA);

  state_t state, state_nxt;

  logic [ROWW-1:0] mem [ENTRIES];
  logic [IDXW-1:0] cnt;
  logic [HIST-1:0] ghr;
  logic [ROWW-1:0] rd_row;

  logic [ROWW-1:0] upd_row;
  logic [IDXW-1:0] upd_idx;
  logic [HIST-1:0] upd_ghr;
  logic            upd_taken;

  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [ROWW-1:0] wr_data;
  logic [ROWW-1:0] new_row;

  logic [IDXW-1:0]     lu_idx, up_idx;
  logic                lu_fire, up_fire, train;
  logic signed [SW:0]  up_sum_x, up_abs;
  logic                unused_bits;

  assign lu_idx  = lu_pc[IDXW+1:2];
  assign up_idx  = up_pc[IDXW+1:2];
  assign lu_fire = lu_valid & lu_ready;
  assign up_fire = up_valid & up_ready;

  // One extra bit so the magnitude of the most negative sum cannot wrap.
  assign up_sum_x = {up_sum[SW-1], up_sum};
  assign up_abs   = up_sum_x[SW] ? -up_sum_x : up_sum_x;
  assign train    = up_mispred | (up_abs <= THETA_X);

  assign unused_bits = ^{lu_pc[31:IDXW+2], lu_pc[1:0], up_pc[31:IDXW+2], up_pc[1:0]};

  perceptron_sum #(
    .HIST  (HIST),
    .WBITS (WBITS),
    .SW    (SW)
  ) u_sum (
    .row (rd_row),
    .ghr (pred_ghr),
    .sum (pred_sum)
  );

  assign pred_taken = pred_valid & ~pred_sum[SW-1];

  always_comb begin
    state_nxt = state;
    lu_ready  = 1'b0;
    up_ready  = 1'b0;
    init_done = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    wr_data   = '0;
    case (state)
      INIT: begin
        init_done = 1'b0;
        wr_en     = 1'b1;
        if (cnt == IDX_MAX) state_nxt = RUN;
      end
      RUN: begin
        up_ready = 1'b1;
        lu_ready = ~(up_valid & up_mispred);
        if (up_fire && train) state_nxt = UPD_WR;
      end
      UPD_WR: begin
        wr_en     = 1'b1;
        wr_idx    = upd_idx;
        wr_data   = new_row;
        state_nxt = RUN;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Saturating +/-1 step per field; bias follows the outcome, weights follow agreement.
  always_comb begin
    logic signed [WBITS:0] wx;
    logic                  inc;
    new_row = upd_row;
    wx      = '0;
    inc     = 1'b0;
    for (int i = 0; i <= HIST; i++) begin
      inc = (i == HIST) ? upd_taken : (upd_ghr[i % HIST] == upd_taken);
      wx  = {upd_row[i*WBITS+WBITS-1], upd_row[i*WBITS +: WBITS]};
      wx  = inc ? (wx + ONE_X) : (wx - ONE_X);
      if (wx > LIM_X)  wx = LIM_X;
      if (wx < -LIM_X) wx = -LIM_X;
      new_row[i*WBITS +: WBITS] = wx[WBITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      cnt        <= '0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_ghr   <= '0;
      rd_row     <= '0;
    end else begin
      state      <= state_nxt;
      pred_valid <= lu_fire;
      if (state == INIT) cnt <= cnt + IDXW'(1);
      if (lu_fire) begin
        rd_row   <= mem[lu_idx];
        pred_ghr <= ghr;
      end
      if (up_fire && up_mispred) ghr <= {up_ghr[HIST-2:0], up_taken};
      else if (pred_valid)       ghr <= {ghr[HIST-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (up_fire && train) begin
      upd_row   <= mem[up_idx];
      upd_idx   <= up_idx;
      upd_ghr   <= up_ghr;
      upd_taken <= up_taken;
    end
  end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Randomised directed bench with a table-of-integers reference predictor.
module tb_perceptron_predictor;

  localparam int SW = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 lu_valid;
  logic [31:0]          lu_pc;
  logic                 lu_ready;
  logic                 pred_valid;
  logic                 pred_taken;
  logic signed [SW-1:0] pred_sum;
  logic [11:0]          pred_ghr;
  logic                 up_valid;
  logic                 up_ready;
  logic [31:0]          up_pc;
  logic [11:0]          up_ghr;
  logic [SW-1:0]        up_sum;
  logic                 up_taken;
  logic                 up_mispred;
  logic                 init_done;

  perceptron_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .lu_valid   (lu_valid),
    .lu_pc      (lu_pc),
    .lu_ready   (lu_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_sum   (pred_sum),
    .pred_ghr   (pred_ghr),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_pc      (up_pc),
    .up_ghr     (up_ghr),
    .up_sum     (up_sum),
    .up_taken   (up_taken),
    .up_mispred (up_mispred),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference state: 64 rows of 12 weights plus bias at index 12.
  int w [64][13];
  int ghr_m = 0;
  int last_obs_sum = 0;
  int last_obs_ghr = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int model_sum(int row, int g);
    int s = w[row][12];
    for (int i = 0; i < 12; i++) s += ((g >> i) & 1) ? w[row][i] : -w[row][i];
    return s;
  endfunction

  function automatic void model_train(int row, int g, int t);
    for (int i = 0; i < 12; i++)
      w[row][i] = clamp(w[row][i] + ((((g >> i) & 1) == t) ? 1 : -1));
    w[row][12] = clamp(w[row][12] + (t != 0 ? 1 : -1));
  endfunction

  function automatic int row_of(logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  task automatic wait_lu_ready();
    int n = 0;
    #1;
    while (!lu_ready && n < 10) begin
      tick();
      n++;
    end
    if (!lu_ready) check("lu_ready_timeout", 0, 1);
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    int exp_sum, exp_ghr, tk;
    lu_valid = 1'b1;
    lu_pc    = pc;
    wait_lu_ready();
    exp_ghr = ghr_m;
    exp_sum = model_sum(row_of(pc), ghr_m);
    tk = (exp_sum >= 0) ? 1 : 0;
    tick();
    lu_valid = 1'b0;
    last_obs_sum = int'(pred_sum);
    last_obs_ghr = int'(pred_ghr);
    check("pred_valid", int'(pred_valid), 1);
    check("pred_sum", int'(pred_sum), exp_sum);
    check("pred_taken", int'(pred_taken), tk);
    check("pred_ghr", int'(pred_ghr), exp_ghr);
    tick();
    ghr_m = ((ghr_m << 1) | tk) & 12'hFFF;
  endtask

  task automatic do_update(input logic [31:0] pc, input int g, input int s,
                           input int t, input int m);
    int tr;
    up_valid   = 1'b1;
    up_pc      = pc;
    up_ghr     = 12'(g);
    up_sum     = SW'(s);
    up_taken   = (t != 0);
    up_mispred = (m != 0);
    #1;
    check("up_ready_accept", int'(up_ready), 1);
    check("lu_ready_vs_mispred", int'(lu_ready), (m != 0) ? 0 : 1);
    tr = (m != 0 || (s <= 37 && s >= -37)) ? 1 : 0;
    tick();
    up_valid   = 1'b0;
    up_mispred = 1'b0;
    if (m != 0) ghr_m = ((g << 1) | (t != 0 ? 1 : 0)) & 12'hFFF;
    if (tr != 0) model_train(row_of(pc), g, t);
    #1;
    check("up_ready_after", int'(up_ready), (tr != 0) ? 0 : 1);
    if (tr != 0) tick();
  endtask

  initial begin
    reset = 1'b1; lu_valid = 1'b0; lu_pc = '0; up_valid = 1'b0; up_pc = '0;
    up_ghr = '0; up_sum = '0; up_taken = 1'b0; up_mispred = 1'b0;
    for (int r = 0; r < 64; r++) for (int i = 0; i < 13; i++) w[r][i] = 0;

    // Reset values
    tick(); tick(); tick();
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_pred_taken", int'(pred_taken), 0);
    check("rst_pred_sum", int'(pred_sum), 0);
    check("rst_pred_ghr", int'(pred_ghr), 0);
    check("rst_lu_ready", int'(lu_ready), 0);
    check("rst_up_ready", int'(up_ready), 0);
    check("rst_init_done", int'(init_done), 0);

    // Partial clear interrupted by reset, then a full 64-cycle clear
    reset = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("mid_init_lu_ready", int'(lu_ready), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check("init_lu_ready", int'(lu_ready), (k == 64) ? 1 : 0);
      check("init_done", int'(init_done), (k == 64) ? 1 : 0);
    end

    // Cleared table predicts taken with zero sum
    for (int k = 0; k < 3; k++) do_lookup($urandom);

    // Drive row 16 to full negative saturation
    for (int k = 0; k < 200; k++)
      do_update(32'h40, 12'hFFF, int'($urandom_range(0, 4094)) - 2047, 0, 1);
    do_update(32'h80, 12'hFFF, 0, 1, 1);
    do_lookup(32'h40);
    check("sat_sum_literal", last_obs_sum, -1651);

    // Confident correct prediction: no training
    do_update(32'h40, 12'hABC, 100, 1, 0);
    do_lookup(32'h40);

    // Misprediction recovery of the global history
    do_lookup(32'h44);
    do_update(32'h48, 12'h123, 5, 1, 1);
    do_lookup(32'h48);
    check("recover_ghr_literal", last_obs_ghr, 12'h247);

    // Mispredict update and lookup presented together
    lu_valid = 1'b1; lu_pc = 32'h4C;
    up_valid = 1'b1; up_pc = 32'h50; up_ghr = 12'h5A5; up_sum = SW'(3);
    up_taken = 1'b0; up_mispred = 1'b1;
    #1;
    check("same_cycle_lu_ready", int'(lu_ready), 0);
    tick();
    up_valid = 1'b0; up_mispred = 1'b0;
    ghr_m = ((12'h5A5 << 1) | 0) & 12'hFFF;
    model_train(row_of(32'h50), 12'h5A5, 0);
    #1;
    check("upd_wr_lu_ready", int'(lu_ready), 0);
    do_lookup(32'h4C);
    check("same_cycle_recover_ghr", last_obs_ghr, 12'hB4A);

    // Lookup of row 5 held while row 5 is written back
    up_valid = 1'b1; up_pc = 32'h14; up_ghr = 12'h0F0; up_sum = SW'(-10);
    up_taken = 1'b1; up_mispred = 1'b0;
    tick();
    up_valid = 1'b0;
    model_train(5, 12'h0F0, 1);
    lu_valid = 1'b1; lu_pc = 32'h14;
    #1;
    check("held_lu_ready", int'(lu_ready), 0);
    do_lookup(32'h14);

    // Random mix of lookups and updates on a handful of rows
    for (int k = 0; k < 40; k++) begin
      logic [31:0] pc;
      int s;
      pc = ($urandom & 32'hFFFF_FF00) | 32'(((5 + $urandom_range(0, 3)) << 2));
      if ($urandom_range(0, 1) == 1) begin
        do_lookup(pc);
      end else begin
        s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100)) - 50
                                        : int'($urandom_range(0, 4094)) - 2047;
        do_update(pc, int'($urandom_range(0, 4095)), s,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
